// File: rtl/ins_exec_rv32i_jb.sv
// Execute-stage unit for RV32I JAL, JALR and conditional branches with a registered result beat.
// Optional taken-transfer counter enabled by defining INS_EXEC_JB_PERF_CNT_EN.
module ins_exec_rv32i_jb #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ins_dec_op,
  input  logic [2:0]       ins_dec_funct3,
  input  logic [XLEN-1:0]  reg_pc_val,
  input  logic [XLEN-1:0]  reg_rs1_val,
  input  logic [XLEN-1:0]  reg_rs2_val,
  input  logic [4:0]       reg_rd,
  input  logic [XLEN-1:0]  imm_ext_ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             reg_pc_w_op,
  output logic [XLEN-1:0]  reg_pc_w_val,
  output logic             reg_w_op,
  output logic [4:0]       reg_w_reg_idx,
  output logic [XLEN-1:0]  reg_w_reg_val,
  output logic             exc_misalign,
  output logic             exc_illegal,
  output logic [XLEN-1:0]  exc_tval,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_cnt
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic            valid;
    logic            pc_w_op;
    logic [XLEN-1:0] pc_w_val;
    logic            w_op;
    logic [4:0]      w_idx;
    logic [XLEN-1:0] w_val;
    logic            misalign;
    logic            illegal;
    logic [XLEN-1:0] tval;
  } res_t;

  res_t             res_q, res_d;
  logic [CNT_W-1:0] perf_cnt_q, perf_cnt_d;

  logic            is_jal, is_jalr, is_br, is_jump;
  logic            br_illegal, br_taken, transfer, misalign;
  logic [XLEN-1:0] rel_target, jalr_sum, target, link_val;
  logic            in_accept;

  assign in_ready  = !res_q.valid || out_ready;
  assign in_accept = in_valid && in_ready;

  // Decode and resolve the transfer for the beat currently on the inputs.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    is_jal     = (ins_dec_op == OP_JAL);
    is_jalr    = (ins_dec_op == OP_JALR);
    is_br      = (ins_dec_op == OP_BRANCH);
    is_jump    = is_jal || is_jalr;
    br_illegal = is_br && (ins_dec_funct3[2:1] == 2'b01);
    br_taken   = 1'b0;
    unique case (ins_dec_funct3)
      3'b000:  br_taken = (reg_rs1_val == reg_rs2_val);
      3'b001:  br_taken = (reg_rs1_val != reg_rs2_val);
      3'b100:  br_taken = ($signed(reg_rs1_val) <  $signed(reg_rs2_val));
      3'b101:  br_taken = ($signed(reg_rs1_val) >= $signed(reg_rs2_val));
      3'b110:  br_taken = (reg_rs1_val <  reg_rs2_val);
      3'b111:  br_taken = (reg_rs1_val >= reg_rs2_val);
      default: br_taken = 1'b0;
    endcase

    rel_target = reg_pc_val + (imm_ext_ext << 1);
    jalr_sum   = reg_rs1_val + imm_ext_ext;
    target     = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : rel_target;
    link_val   = reg_pc_val + XLEN'(4);
    transfer   = is_jump || (is_br && !br_illegal && br_taken);
    misalign   = transfer && ((IALIGN == 32) ? target[1] : target[0]);
  end

  // Result register: load on accept, clear once drained, otherwise hold for the stall.
  always_comb begin
    res_d = res_q;
    if (in_accept) begin
      res_d          = '0;
      res_d.valid    = is_jump || is_br;
      res_d.illegal  = br_illegal;
      res_d.misalign = misalign;
      res_d.tval     = misalign ? target : '0;
      res_d.pc_w_op  = transfer && !misalign;
      res_d.pc_w_val = (transfer && !misalign) ? target : '0;
      if (is_jump && !misalign && (reg_rd != 5'd0)) begin
        res_d.w_op  = 1'b1;
        res_d.w_idx = reg_rd;
        res_d.w_val = link_val;
      end
    end else if (out_ready) begin
      res_d = '0;
    end
  end

`ifdef INS_EXEC_JB_PERF_CNT_EN
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (perf_clr) begin
      perf_cnt_d = '0;
    end else if (res_q.valid && out_ready && res_q.pc_w_op) begin
      perf_cnt_d = perf_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_cnt_d      = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments; the whole result register
  // resets so a beat stalled at reset time can never reappear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q      <= '0;
      perf_cnt_q <= '0;
    end else begin
      res_q      <= res_d;
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign out_valid     = res_q.valid;
  assign reg_pc_w_op   = res_q.pc_w_op;
  assign reg_pc_w_val  = res_q.pc_w_val;
  assign reg_w_op      = res_q.w_op;
  assign reg_w_reg_idx = res_q.w_idx;
  assign reg_w_reg_val = res_q.w_val;
  assign exc_misalign  = res_q.misalign;
  assign exc_illegal   = res_q.illegal;
  assign exc_tval      = res_q.tval;
  assign perf_cnt      = perf_cnt_q;

endmodule

// File: tb/tb_ins_exec_rv32i_jb.sv
// Self-checking bench for ins_exec_rv32i_jb: directed spec vectors plus randomized traffic
// against a behavioural model; a second instance covers IALIGN=16.
module tb_ins_exec_rv32i_jb;
  localparam int XLEN = 32;

  typedef struct packed {
    logic        valid;
    logic        pc_w_op;
    logic [31:0] pc_w_val;
    logic        w_op;
    logic [4:0]  w_idx;
    logic [31:0] w_val;
    logic        mis;
    logic        ill;
    logic [31:0] tval;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, perf_clr;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [31:0] pc, rs1, rs2, imm;
  logic [4:0]  rd;

  logic        in_ready, in_ready16;
  logic        ov, pwo, wo, mis, ill;
  logic [31:0] pwv, wv, tval, cnt;
  logic [4:0]  widx;
  logic        ov16, pwo16, wo16, mis16, ill16;
  logic [31:0] pwv16, wv16, tval16, cnt16;
  logic [4:0]  widx16;

  res_t        act, act16, exp, exp16;
  logic [31:0] exp_cnt;
  int          total = 0;
  int          bad   = 0;

  assign act   = '{ov, pwo, pwv, wo, widx, wv, mis, ill, tval};
  assign act16 = '{ov16, pwo16, pwv16, wo16, widx16, wv16, mis16, ill16, tval16};

  always #5 clk = ~clk;

  ins_exec_rv32i_jb #(.XLEN(32), .IALIGN(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ins_dec_op(op), .ins_dec_funct3(f3), .reg_pc_val(pc), .reg_rs1_val(rs1),
    .reg_rs2_val(rs2), .reg_rd(rd), .imm_ext_ext(imm), .out_valid(ov),
    .out_ready(out_ready), .reg_pc_w_op(pwo), .reg_pc_w_val(pwv), .reg_w_op(wo),
    .reg_w_reg_idx(widx), .reg_w_reg_val(wv), .exc_misalign(mis), .exc_illegal(ill),
    .exc_tval(tval), .perf_clr(perf_clr), .perf_cnt(cnt)
  );

  ins_exec_rv32i_jb #(.XLEN(32), .IALIGN(16), .CNT_W(32)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .ins_dec_op(op), .ins_dec_funct3(f3), .reg_pc_val(pc), .reg_rs1_val(rs1),
    .reg_rs2_val(rs2), .reg_rd(rd), .imm_ext_ext(imm), .out_valid(ov16),
    .out_ready(out_ready), .reg_pc_w_op(pwo16), .reg_pc_w_val(pwv16), .reg_w_op(wo16),
    .reg_w_reg_idx(widx16), .reg_w_reg_val(wv16), .exc_misalign(mis16), .exc_illegal(ill16),
    .exc_tval(tval16), .perf_clr(perf_clr), .perf_cnt(cnt16)
  );

  // Architectural result of one instruction, straight from the ISA rules.
  function automatic res_t ref_model(input logic [6:0] o, input logic [2:0] f,
                                     input logic [31:0] p, input logic [31:0] a,
                                     input logic [31:0] b, input logic [4:0] d,
                                     input logic [31:0] i, input int ialign);
    res_t        r;
    logic [31:0] t;
    logic        taken, link;
    r = '0;
    link = 1'b0;
    if (o == 7'b1101111) begin
      t = p + i * 2; taken = 1'b1; link = 1'b1;
    end else if (o == 7'b1100111) begin
      t = (a + i) & 32'hFFFF_FFFE; taken = 1'b1; link = 1'b1;
    end else if (o == 7'b1100011) begin
      t = p + i * 2;
      case (f)
        3'd0: taken = (a == b);
        3'd1: taken = (a != b);
        3'd4: taken = (int'(a) < int'(b));
        3'd5: taken = !(int'(a) < int'(b));
        3'd6: taken = (a < b);
        3'd7: taken = !(a < b);
        default: begin
          r.valid = 1'b1; r.ill = 1'b1;
          return r;
        end
      endcase
    end else begin
      return r;
    end
    r.valid = 1'b1;
    if (!taken) return r;
    if ((ialign == 32) ? (t % 4 >= 2) : (t % 2 == 1)) begin
      r.mis = 1'b1; r.tval = t;
      return r;
    end
    r.pc_w_op = 1'b1; r.pc_w_val = t;
    if (link && d != 0) begin
      r.w_op = 1'b1; r.w_idx = d; r.w_val = p + 4;
    end
    return r;
  endfunction

  // Advance one clock, updating the expected output register from the handshake rules.
  task automatic tick();
    logic acc, hs;
    acc = in_valid && (!exp.valid || out_ready);
    hs  = exp.valid && out_ready;
`ifdef INS_EXEC_JB_PERF_CNT_EN
    if (perf_clr) exp_cnt = 0;
    else if (hs && exp.pc_w_op) exp_cnt = exp_cnt + 1;
`endif
    if (acc) begin
      exp   = ref_model(op, f3, pc, rs1, rs2, rd, imm, 32);
      exp16 = ref_model(op, f3, pc, rs1, rs2, rd, imm, 16);
    end else if (hs) begin
      exp = '0; exp16 = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_beat(input logic [6:0] o, input logic [2:0] f, input logic [31:0] p,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] i);
    op = o; f3 = f; pc = p; rs1 = a; rs2 = b; rd = d; imm = i;
  endtask

  task automatic rand_beat();
    logic [31:0] pool [6];
    int          k;
    pool = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, $urandom};
    k = $urandom_range(0, 9);
    op  = (k < 2) ? 7'b1101111 : (k < 4) ? 7'b1100111 : (k < 9) ? 7'b1100011 : 7'b0010011;
    f3  = 3'($urandom);
    pc  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    rs1 = pool[$urandom_range(0, 5)];
    rs2 = pool[$urandom_range(0, 5)];
    rd  = 5'($urandom);
    imm = 32'($signed(12'($urandom)));
  endtask

  task automatic test_reset();
    total++;
    if (act !== res_t'('0)) begin bad++; $display("FAIL reset_outputs: got %h want 0", act); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++;
    if (cnt !== 32'd0) begin bad++; $display("FAIL reset_perf: got %h want 0", cnt); end
  endtask

  task automatic test_directed();
    out_ready = 1'b1; in_valid = 1'b1;
    set_beat(7'b1101111, 3'd0, 32'h100, 32'h0, 32'h0, 5'd1, 32'h10);
    tick();
    total++;
    if (act !== exp || pwv !== 32'h120 || wv !== 32'h104 || !wo || widx !== 5'd1 || !ov) begin
      bad++; $display("FAIL jal_basic: got %h want %h", act, exp);
    end
    set_beat(7'b1100111, 3'd0, 32'h0, 32'h2001, 32'h0, 5'd0, 32'h4);
    tick();
    total++;
    if (act !== exp || pwv !== 32'h2004 || wo !== 1'b0 || !pwo) begin
      bad++; $display("FAIL jalr_rd0: got %h want %h", act, exp);
    end
    set_beat(7'b1100011, 3'b100, 32'h40, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h8);
    tick();
    total++;
    if (act !== exp || !pwo || pwv !== 32'h50) begin
      bad++; $display("FAIL blt_signed: got %h want %h", act, exp);
    end
    set_beat(7'b1100011, 3'b110, 32'h40, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h8);
    tick();
    total++;
    if (act !== exp || pwo || wo || mis || ill || !ov) begin
      bad++; $display("FAIL bltu_unsigned: got %h want %h", act, exp);
    end
    set_beat(7'b1100011, 3'b011, 32'h40, 32'h1, 32'h1, 5'd0, 32'h8);
    tick();
    total++;
    if (act !== exp || !ill || pwo || tval !== 32'h0) begin
      bad++; $display("FAIL illegal_f3: got %h want %h", act, exp);
    end
    set_beat(7'b1101111, 3'd0, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd5, 32'h2);
    tick();
    total++;
    if (act !== exp || pwv !== 32'h0 || wv !== 32'h0 || !wo) begin
      bad++; $display("FAIL jal_wrap: got %h want %h", act, exp);
    end
    set_beat(7'b0110011, 3'd0, 32'h100, 32'h0, 32'h0, 5'd1, 32'h10);
    tick();
    total++;
    if (act !== exp || ov !== 1'b0) begin
      bad++; $display("FAIL unsupported_op: got %h want %h", act, exp);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_ialign();
    out_ready = 1'b1; in_valid = 1'b1;
    set_beat(7'b1101111, 3'd0, 32'h100, 32'h0, 32'h0, 5'd3, 32'h1);
    tick();
    total++;
    if (act !== exp || !mis || tval !== 32'h102 || pwo || wo) begin
      bad++; $display("FAIL misalign_32: got %h want %h", act, exp);
    end
    total++;
    if (act16 !== exp16 || mis16 || !pwo16 || pwv16 !== 32'h102 || wv16 !== 32'h104) begin
      bad++; $display("FAIL align_16: got %h want %h", act16, exp16);
    end
    set_beat(7'b1100011, 3'b000, 32'h201, 32'h5, 32'h5, 5'd0, 32'h2);
    tick();
    total++;
    if (act !== exp || act16 !== exp16 || !mis16 || tval16 !== 32'h205) begin
      bad++; $display("FAIL misalign_16_branch: got %h/%h want %h/%h", act, act16, exp, exp16);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    res_t held;
    out_ready = 1'b1; in_valid = 1'b1;
    set_beat(7'b1101111, 3'd0, 32'h300, 32'h0, 32'h0, 5'd7, 32'h20);
    tick();
    held = exp;
    out_ready = 1'b0;
    set_beat(7'b1100011, 3'b001, 32'h400, 32'h1, 32'h2, 5'd0, 32'h4);
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (act !== held || act !== exp || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold c%0d: got %h rdy=%b want %h rdy=0", c, act, in_ready, held);
      end
    end
    out_ready = 1'b1; #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      rand_beat();
      if (c % 2 == 0) op = 7'b1100011;
      tick();
      total++;
      if (act !== exp || cnt !== exp_cnt) begin
        bad++; $display("FAIL b2b c%0d: got %h cnt=%h want %h cnt=%h", c, act, cnt, exp, exp_cnt);
      end
    end
    in_valid = 1'b0;
    tick();
    total++;
    if (act !== exp || cnt !== exp_cnt) begin
      bad++; $display("FAIL b2b_drain: got %h cnt=%h want %h cnt=%h", act, cnt, exp, exp_cnt);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      perf_clr  = ($urandom_range(0, 15) == 0);
      tick();
      perf_clr = 1'b0;
      total++;
      if (act !== exp || act16 !== exp16 || cnt !== exp_cnt || in_ready !== (!exp.valid || out_ready)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL random c%0d: got %h/%h cnt=%h want %h/%h cnt=%h",
                                c, act, act16, cnt, exp, exp16, exp_cnt);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1; in_valid = 1'b1;
    set_beat(7'b1101111, 3'd0, 32'h500, 32'h0, 32'h0, 5'd2, 32'h8);
    tick();
    out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    exp = '0; exp16 = '0; exp_cnt = 0;
    #1;
    total++;
    if (act !== res_t'('0) || act16 !== res_t'('0) || cnt !== 32'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_stall: got %h cnt=%h rdy=%b want 0", act, cnt, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    total++;
    if (act !== res_t'('0) || ov !== 1'b0) begin
      bad++; $display("FAIL no_stale_beat: got %h want 0", act);
    end
    out_ready = 1'b1; in_valid = 1'b1;
    set_beat(7'b1100111, 3'd0, 32'h600, 32'h1000, 32'h0, 5'd9, 32'h10);
    tick();
    total++;
    if (act !== exp || pwv !== 32'h1010) begin
      bad++; $display("FAIL after_reset_beat: got %h want %h", act, exp);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; perf_clr = 1'b0;
    set_beat(7'b0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    exp = '0; exp16 = '0; exp_cnt = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_ialign();
    test_back_to_back();
    test_random();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
